// File: rtl/cordic_phase_gen_if.sv
// Control and angle-stream bundle for cordic_phase_gen.
// The master side is the generator; the slave side is the host/consumer.
interface cordic_phase_gen_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) ();
  logic             start;
  logic [31:0]      ftw;
  logic [31:0]      phase_init;
  logic [CNT_W-1:0] burst_len;
  logic             busy;
  logic             done;
  logic [N-1:0]     angle;
  logic             flip;
  logic             valid;
  logic             ready;

  modport master (
    input  start, ftw, phase_init, burst_len, ready,
    output busy, done, angle, flip, valid
  );

  modport slave (
    output start, ftw, phase_init, burst_len, ready,
    input  busy, done, angle, flip, valid
  );
endinterface

// File: rtl/cordic_phase_gen.sv
// Phase-accumulator angle source for a trig-mode CORDIC: fold to [-pi/2, pi/2), scale to CORDIC format.
// Two-stage pipeline (valid 2 cycles after start); output holds while valid & !ready, no bubbles when ready.
module cordic_phase_gen #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cordic_phase_gen_if.master bus
);
  localparam logic [31:0] K = 32'hC90FDAA2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q, state_d;

  logic [31:0]        acc_q, acc_d, ftw_q, ftw_d;
  logic [CNT_W-1:0]   len_q, len_d, issued_q, issued_d, accepted_q, accepted_d;
  logic               s1_vld_q, s1_vld_d, s1_flip_q, s1_flip_d;
  logic signed [31:0] s1_r_q, s1_r_d;
  logic               vld_q, vld_d, flip_q, flip_d;
  logic [N-1:0]       angle_q, angle_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               s2_load, s1_load, start_ok, issue, last_issue, drained;
  logic signed [64:0] r_ext, k_ext, prod;
  logic [31:0]        a32;
  logic               unused_bits;

  assign s2_load    = !vld_q || bus.ready;
  assign s1_load    = !s1_vld_q || s2_load;
  assign start_ok   = (state_q == IDLE) && bus.start && !done_q;
  assign issue      = (state_q == RUN) && s1_load;
  assign last_issue = issue && ((issued_q + CNT_W'(1)) == len_q);
  assign drained    = (accepted_d == len_q) && !s1_vld_d && !vld_d;

  // Signed r times unsigned K; the >>>32 is the slice, which floors toward -inf.
  assign r_ext       = {{33{s1_r_q[31]}}, s1_r_q};
  assign k_ext       = {33'd0, K};
  assign prod        = r_ext * k_ext;
  assign a32         = prod[63:32];
  assign unused_bits = ^{prod[64], prod[31:0], a32};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = (bus.burst_len == '0) ? DRAIN : RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE:    if (start_ok) busy_d = 1'b1;
      DRAIN:   if (drained) begin
                 busy_d = 1'b0;
                 done_d = 1'b1;
               end
      default: ;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    ftw_d      = ftw_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    s1_vld_d   = s1_vld_q;
    s1_r_d     = s1_r_q;
    s1_flip_d  = s1_flip_q;
    vld_d      = vld_q;
    angle_d    = angle_q;
    flip_d     = flip_q;

    if (start_ok) begin
      ftw_d      = bus.ftw;
      len_d      = bus.burst_len;
      acc_d      = bus.phase_init;
      issued_d   = '0;
      accepted_d = '0;
    end

    if (vld_q && bus.ready) accepted_d = accepted_q + CNT_W'(1);

    if (s2_load) begin
      vld_d = s1_vld_q;
      if (s1_vld_q) begin
        angle_d = a32[31 -: N];
        flip_d  = s1_flip_q;
      end
    end

    // Quadrants 01/10 are |theta| >= pi/2: subtracting 2^31 is a top-bit flip.
    if (issue) begin
      s1_vld_d  = 1'b1;
      s1_flip_d = acc_q[31] ^ acc_q[30];
      s1_r_d    = (acc_q[31] ^ acc_q[30]) ? {~acc_q[31], acc_q[30:0]} : acc_q;
      acc_d     = acc_q + ftw_q;
      issued_d  = issued_q + CNT_W'(1);
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      ftw_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_r_q     <= '0;
      s1_flip_q  <= 1'b0;
      vld_q      <= 1'b0;
      angle_q    <= '0;
      flip_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_q      <= ftw_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      s1_vld_q   <= s1_vld_d;
      s1_r_q     <= s1_r_d;
      s1_flip_q  <= s1_flip_d;
      vld_q      <= vld_d;
      angle_q    <= angle_d;
      flip_q     <= flip_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.valid = vld_q;
  assign bus.angle = angle_q;
  assign bus.flip  = flip_q;
endmodule

// File: doc/cordic_phase_gen.md
Name: cordic_phase_gen

Overview:
- Upstream angle source for CORDIC_UNIT in trig mode (trig_rot=1).
- Runs a 32-bit phase accumulator (one full turn = 2^32) and emits a burst of angles on a valid/ready stream, one per accepted transfer.
- Folds each phase into [-pi/2, pi/2) so the CORDIC converges, and converts it to the CORDIC signed fixed-point angle format: 3 integer bits including sign, N-3 fractional bits, pi/2 = 843314857 at N=32.
- Outputs a flip flag; downstream logic negates both sin and cos when flip=1.

Parameters:
- N, 32, output angle width (matches the CORDIC data size); fractional bits = N-3.
- CNT_W, 16, width of the burst length and sample counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: one clock, synchronous, active-high.
- start  in  1  single-cycle request to begin a burst; sampled in IDLE only.
- ftw  in  32  frequency tuning word (phase increment per sample); latched on start.
- phase_init  in  32  starting phase; latched on start.
- burst_len  in  CNT_W  number of samples in the burst; latched on start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last sample is accepted downstream.
- angle  out  N  folded angle in CORDIC format, two's complement.
- flip  out  1  1 means the true sin/cos are the negated CORDIC results.
- valid  out  1  angle and flip are valid.
- ready  in  1  downstream accepts when valid & ready.

Behaviour:
- Reset, synchronous: state=IDLE. busy, done, valid, flip, angle, stage-1 valid, accumulator and counters all 0. Reset mid-burst discards everything in flight and gives no done pulse.

State machine (IDLE, RUN, DRAIN):
- IDLE + start: latch ftw and burst_len, set acc=phase_init, issued=0, accepted=0.
  - burst_len=0: go directly to DRAIN; done pulses on the next cycle with no samples emitted.
  - Otherwise: go to RUN.
- RUN: when stage 1 can load, push acc into stage 1, set acc=acc+ftw (mod 2^32), issued++. When issued reaches burst_len, go to DRAIN.
- DRAIN: once accepted==burst_len and both stages are empty, pulse done for 1 cycle, drop busy in the same cycle, go to IDLE.
- start is ignored outside IDLE. A start coincident with done is ignored.

Stage 1 (fold):
- p = issued phase. Bits [31:30] of 01 or 10 mean |theta| >= pi/2.
- In that case r = p - 2^31 (signed), flip=1. Otherwise r = p (signed), flip=0.
- Resulting r lies in [-2^30, 2^30).

Stage 2 (scale):
- A32 = (r * K) >>> 32, with K = 0xC90FDAA2 (pi/4 in Q0.32).
- Signed 32x33-bit product, arithmetic shift, so results round toward -inf.
- angle = A32[31:32-N].

Pipeline and handshake:
- Stage 2 (the output register) loads when !valid | ready.
- Stage 1 loads when it is empty or stage 2 is loading.
- No bubbles with ready held high: one sample per cycle.
- valid first rises 2 cycles after the start edge.
- While valid & !ready: angle and flip hold stable, no sample is lost or duplicated, and the accumulator advances only on an issue.
- accepted increments on every valid & ready.

Test Plan:
- Reset: drive rst for 2 cycles mid-burst, then release → busy=done=valid=0, angle=0; a new start works normally.
- 60°: phase_init=0x2AAAAAAB, ftw=0, burst_len=1, ready=1 → angle=562209904 ±1 (0x2182A470 region), flip=0, valid for 1 cycle, then done pulse.
- 135°: phase_init=0x60000000, burst_len=1 → r=-0x20000000, angle=-421657429, flip=1. 180° with phase_init=0x80000000 → angle=0, flip=1.
- Quadrant sweep: phase_init=0, ftw=0x40000000, burst_len=4, ready=1 → (angle, flip) = (0,0), (-843314857,1), (0,1), (-843314857,0) on 4 consecutive cycles; done exactly 1 cycle after the 4th transfer.
- Backpressure: burst_len=8, ftw=0x10000000, ready low for 3 cycles after the 2nd transfer → outputs hold during the stall; exactly 8 transfers with phases 0..7×0x10000000 in order; no duplicates.
- Edge cases:
  - burst_len=0 → busy for 1 cycle, done pulse, valid never asserted.
  - start while busy → ignored; the burst completes unchanged.
